dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
Load/store unit between the EX/MEM pipeline register and the data memory port; consumed by the MEM/WB stage and the hazard unit.
- Takes one load/store request per transaction.
- Generates a word-aligned bus access with byte enables.
- Waits through variable memory latency, then returns one response pulse with aligned, sign/zero-extended load data.
- Holds the pipeline stalled while the access is outstanding.

Parameters:
TIMEOUT, 255, max cycles in REQ+WAIT before aborting with error (8-bit counter, 1..255)
RESET_ADDR_ZERO, 1, when 1 bus_addr_o/bus_wdata_o are forced to 0 while idle

Ports:
clk  input  1  clock, rising edge
reset_ni  input  1  asynchronous, active-low reset
req_valid_i  input  1  request present from MEM stage
req_we_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address (ALU result)
req_wdata_i  input  32  store data (rs2 value, low bits significant)
req_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned_i  input  1  load zero-extend (LBU/LHU)
req_ready_o  output  1  request accepted this cycle when high with req_valid_i
rsp_valid_o  output  1  one-cycle completion pulse (loads and stores)
rsp_rdata_o  output  32  extended load data; 0 for stores/errors
rsp_err_o  output  1  misaligned, illegal size or timeout; valid with rsp_valid_o
stall_o  output  1  pipeline stall request to hazard unit
bus_req_o  output  1  bus request, held until bus_gnt_i
bus_we_o  output  1  bus write
bus_addr_o  output  32  {req_addr[31:2],2'b00}
bus_wdata_o  output  32  lane-replicated store data
bus_be_o  output  4  byte enables
bus_gnt_i  input  1  request granted (address phase done)
bus_rvalid_i  input  1  data phase done (load data valid / store ack)
bus_rdata_i  input  32  raw word read data

Behaviour:
- Reset (async, reset_ni=0): state IDLE, counter 0, captured request cleared; all outputs 0 except req_ready_o=1. Reset mid-transaction abandons it: no rsp_valid_o, no further bus_req_o.
- States: IDLE, REQ, WAIT, RESP. req_ready_o = (state==IDLE).
- IDLE: on req_valid_i, register addr/size/we/unsigned/wdata.
  - Request legal → REQ.
  - Request illegal → RESP with err. Illegal = size 3; half with addr[0]=1; word with addr[1:0]≠0.
  - Illegal requests never assert bus_req_o.
- REQ: bus_req_o=1, bus_we_o/addr/wdata/be stable.
  - On bus_gnt_i → WAIT.
  - If bus_gnt_i and bus_rvalid_i arrive in the same cycle → RESP directly, data captured.
- WAIT: on bus_rvalid_i capture bus_rdata_i → RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, then → IDLE. Requests are not accepted in RESP.
- Timeout: counter increments each cycle in REQ/WAIT and clears on entry to IDLE. At count==TIMEOUT → RESP with rsp_err_o=1, rsp_rdata_o=0; bus_req_o drops.
- bus_rvalid_i/bus_gnt_i seen in IDLE or RESP are ignored; this covers late responses after a timeout.
- stall_o = (req_valid_i & state==IDLE) | state==REQ | state==WAIT. stall_o is 0 in RESP so the pipeline advances and captures the response.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: unchanged
- Load data: shifted = rdata >> (8*addr[1:0]).
  - byte: sign/zero-extend shifted[7:0]
  - half: sign/zero-extend shifted[15:0]
  - word: pass through
  - Stores return rsp_rdata_o=0.
- Minimum latency with gnt in first REQ cycle and rvalid next cycle: accept at cycle 0, bus_req at 1, rvalid at 2, rsp_valid at 3.

Decomposition:
- Package dmem_lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_ILL
  - state enum (IDLE/REQ/WAIT/RESP)
  - misalignment predicate function
- Sub-module lsu_align (combinational): produces be/replicated wdata from size+addr, and extended load data from rdata+size+addr[1:0]+unsigned.
- FSM and counter stay in dmem_lsu.

Test Plan:
- Store word addr 0x100, data 0xDEADBEEF, gnt immediate, rvalid next cycle:
  - bus_be=4'hF, bus_addr=0x100
  - rsp_valid at cycle 3, rdata=0, err=0
  - stall_o high cycles 0-2, low cycle 3
- Load byte signed addr 0x203, bus_rdata=0x80FF_1234 → bus_be=4'b1000, rsp_rdata=0xFFFFFF80; same with unsigned → 0x00000080.
- Store half addr 0x22, wdata 0x0000ABCD → bus_be=4'b1100, bus_wdata=0xABCDABCD.
- Misaligned word load addr 0x105 → no bus_req_o, rsp_valid one cycle after accept, err=1.
- Grant delayed 3 cycles, rvalid delayed 5 → bus_req held exactly until gnt, one rsp_valid pulse; with TIMEOUT=4 and no rvalid → err=1, rdata=0, and a later stray rvalid is ignored.
- Assert reset_ni=0 while in WAIT → outputs cleared asynchronously, no rsp_valid; after release a new load completes normally.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared encodings and helpers for the data-memory load/store unit.
//   - access size encodings (SZ_*)
//   - FSM state constants and the state enum built on them
//   - lsu_misaligned(): legality check for a size / low address pair
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_ILL = 2'd3;

  // Raw state codes kept as constants so legacy code that compares against
  // the numeric encoding still lines up with the enum below.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_e;

  // High when the request must not reach the bus: illegal size, or a
  // half/word access that is not naturally aligned.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   size_i      access size (SZ_B/SZ_H/SZ_W)
//   addr_lo_i   byte offset within the word
//   wdata_i     store data, low bits significant
//   rdata_i     raw word read from the bus
//   unsigned_i  zero-extend loads when high
//   be_o        byte enables for the word access
//   wdata_o     store data replicated across all lanes
//   rdata_o     load data shifted down and sign/zero-extended
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic        unsigned_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between EX/MEM and the data memory port.
// Accepts one request in IDLE, drives a word-aligned bus access with byte
// enables, waits out the memory latency and returns a single rsp_valid_o
// pulse with extended load data. stall_o holds the pipeline meanwhile.
//   clk, reset_ni        clock / async active-low reset
//   req_*                request from the MEM stage, req_ready_o = idle
//   rsp_valid_o/_rdata_o/_err_o   one-cycle completion
//   stall_o              stall request to the hazard unit
//   bus_*                data memory port (req/gnt address phase, rvalid data phase)
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT         = 255,
  parameter bit          RESET_ADDR_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  // Last count value seen in REQ/WAIT before the access is abandoned, so the
  // unit spends at most TIMEOUT cycles in REQ+WAIT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] raw_q, raw_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;

  logic        timeout;
  logic        in_req;
  logic        in_resp;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  lsu_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (raw_q),
    .unsigned_i (uns_q),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (rdata_ext)
  );

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raw_d   = raw_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          raw_d   = '0;
          if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      // A completion that coincides with the timeout cycle still wins.
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_gnt_i && bus_rvalid_i) begin
          raw_d   = bus_rdata_i;
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (bus_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_rvalid_i) begin
          raw_d   = bus_rdata_i;
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      raw_q   <= raw_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  assign in_req  = (state_q == S_REQ);
  assign in_resp = (state_q == S_RESP);

  assign req_ready_o = (state_q == S_IDLE);
  assign stall_o     = (req_valid_i && state_q == S_IDLE) || in_req || (state_q == S_WAIT);

  assign rsp_valid_o = in_resp;
  assign rsp_err_o   = in_resp && err_q;
  assign rsp_rdata_o = (in_resp && !err_q && !we_q) ? rdata_ext : '0;

  assign bus_req_o   = in_req;
  assign bus_we_o    = in_req && we_q;
  assign bus_be_o    = in_req ? be : '0;
  assign bus_addr_o  = (in_req || !RESET_ADDR_ZERO) ? {addr_q[31:2], 2'b00} : '0;
  assign bus_wdata_o = (in_req || !RESET_ADDR_ZERO) ? wdata_rep : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu.
// u_dut uses the default TIMEOUT; u_dut_to (TIMEOUT=4) shares the same
// stimulus and is only checked in the timeout scenarios.
module tb_dmem_lsu;

  logic        clk;
  logic        reset_ni;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  logic        ready, rsp_valid, rsp_err, stall, bus_req, bus_we;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        t_ready, t_rsp_valid, t_rsp_err, t_stall, t_bus_req, t_bus_we;
  logic [31:0] t_rsp_rdata, t_bus_addr, t_bus_wdata;
  logic [3:0]  t_bus_be;

  int unsigned check_count = 0;
  int unsigned error_count = 0;

  dmem_lsu u_dut (
    .clk(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_ready_o(ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .stall_o(stall),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_be_o(bus_be),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  dmem_lsu #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_ready_o(t_ready), .rsp_valid_o(t_rsp_valid), .rsp_rdata_o(t_rsp_rdata),
    .rsp_err_o(t_rsp_err), .stall_o(t_stall),
    .bus_req_o(t_bus_req), .bus_we_o(t_bus_we), .bus_addr_o(t_bus_addr),
    .bus_wdata_o(t_bus_wdata), .bus_be_o(t_bus_be),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Next cycle: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
  endtask

  // Minimum-latency transfer: gnt in first REQ cycle, rvalid the next.
  task automatic run_xfer(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic uns,
                          input logic [31:0] rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    logic [31:0] waddr;
    waddr = addr & 32'hFFFF_FFFC;
    cyc(); issue(we, addr, wd, size, uns); #1;
    chk({tag, ".c0_stall"}, 32'(stall), 32'd1);
    chk({tag, ".c0_ready"}, 32'(ready), 32'd1);
    chk({tag, ".c0_busreq"}, 32'(bus_req), 32'd0);
    cyc(); req_valid = 1'b0; bus_gnt = 1'b1; #1;
    chk({tag, ".c1_busreq"}, 32'(bus_req), 32'd1);
    chk({tag, ".c1_be"}, 32'(bus_be), 32'(exp_be));
    chk({tag, ".c1_addr"}, bus_addr, waddr);
    chk({tag, ".c1_wdata"}, bus_wdata, exp_wd);
    chk({tag, ".c1_we"}, 32'(bus_we), 32'(we));
    chk({tag, ".c1_stall"}, 32'(stall), 32'd1);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd; #1;
    chk({tag, ".c2_stall"}, 32'(stall), 32'd1);
    chk({tag, ".c2_busreq"}, 32'(bus_req), 32'd0);
    chk({tag, ".c2_rspv"}, 32'(rsp_valid), 32'd0);
    cyc(); bus_rvalid = 1'b0; bus_rdata = '0; #1;
    chk({tag, ".c3_rspv"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".c3_rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".c3_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".c3_stall"}, 32'(stall), 32'd0);
    chk({tag, ".c3_ready"}, 32'(ready), 32'd0);
    cyc(); #1;
    chk({tag, ".c4_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".c4_ready"}, 32'(ready), 32'd1);
    chk({tag, ".c4_addr_idle"}, bus_addr, 32'd0);
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] addr, input logic [1:0] size);
    cyc(); issue(1'b0, addr, 32'h0, size, 1'b0); #1;
    chk({tag, ".c0_busreq"}, 32'(bus_req), 32'd0);
    cyc(); req_valid = 1'b0; #1;
    chk({tag, ".c1_rspv"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".c1_err"}, 32'(rsp_err), 32'd1);
    chk({tag, ".c1_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".c1_busreq"}, 32'(bus_req), 32'd0);
    chk({tag, ".c1_stall"}, 32'(stall), 32'd0);
    cyc(); #1;
    chk({tag, ".c2_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".c2_busreq"}, 32'(bus_req), 32'd0);
    chk({tag, ".c2_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin : stim
    int unsigned pulses;
    reset_ni = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #2;
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.rspv", 32'(rsp_valid), 32'd0);
    chk("rst.busreq", 32'(bus_req), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.be", 32'(bus_be), 32'd0);
    cyc(); reset_ni = 1'b1;

    run_xfer("sw",    1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0);
    run_xfer("lb",    1'b0, 32'h203, 32'h0,        2'd0, 1'b0, 32'h80FF1234, 4'h8, 32'h0,        32'hFFFFFF80);
    run_xfer("lbu",   1'b0, 32'h203, 32'h0,        2'd0, 1'b1, 32'h80FF1234, 4'h8, 32'h0,        32'h00000080);
    run_xfer("sh",    1'b1, 32'h022, 32'h0000ABCD, 2'd1, 1'b0, 32'h0,        4'hC, 32'hABCDABCD, 32'h0);
    run_xfer("sb",    1'b1, 32'h011, 32'h123456A5, 2'd0, 1'b0, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h0);
    run_xfer("lh",    1'b0, 32'h000, 32'h0,        2'd1, 1'b0, 32'h12348765, 4'h3, 32'h0,        32'hFFFF8765);
    run_xfer("lhu",   1'b0, 32'h002, 32'h0,        2'd1, 1'b1, 32'h12348765, 4'hC, 32'h0,        32'h00001234);
    run_xfer("lb_p",  1'b0, 32'h001, 32'h0,        2'd0, 1'b0, 32'h00007F00, 4'h2, 32'h0,        32'h0000007F);
    run_xfer("lw",    1'b0, 32'h040, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 4'hF, 32'h0,        32'hCAFEF00D);

    run_illegal("mis_w", 32'h105, 2'd2);
    run_illegal("mis_h", 32'h023, 2'd1);
    run_illegal("ill_sz", 32'h100, 2'd3);

    // Grant after 3 extra REQ cycles, rvalid 5 cycles after grant.
    pulses = 0;
    cyc(); issue(1'b0, 32'h300, 32'h0, 2'd2, 1'b0); #1;
    for (int unsigned c = 1; c <= 11; c++) begin
      cyc();
      req_valid  = 1'b0;
      bus_gnt    = (c == 4);
      bus_rvalid = (c == 9);
      bus_rdata  = (c == 9) ? 32'h0BADC0DE : 32'h0;
      #1;
      if (rsp_valid) pulses++;
      if (c <= 4) chk($sformatf("dly.c%0d_busreq", c), 32'(bus_req), 32'd1);
      if (c >= 5 && c <= 9) begin
        chk($sformatf("dly.c%0d_busreq", c), 32'(bus_req), 32'd0);
        chk($sformatf("dly.c%0d_stall", c), 32'(stall), 32'd1);
      end
      if (c == 10) chk("dly.rdata", rsp_rdata, 32'h0BADC0DE);
    end
    chk("dly.pulses", pulses, 32'd1);

    // Timeout in REQ (u_dut_to); u_dut is then drained with gnt+rvalid together.
    cyc(); issue(1'b0, 32'h400, 32'h0, 2'd2, 1'b0); #1;
    for (int unsigned c = 1; c <= 4; c++) begin
      cyc(); req_valid = 1'b0; #1;
      chk($sformatf("toreq.c%0d_busreq", c), 32'(t_bus_req), 32'd1);
      chk($sformatf("toreq.c%0d_rspv", c), 32'(t_rsp_valid), 32'd0);
    end
    cyc(); bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5A5A0001; #1;
    chk("toreq.rspv", 32'(t_rsp_valid), 32'd1);
    chk("toreq.err", 32'(t_rsp_err), 32'd1);
    chk("toreq.rdata", t_rsp_rdata, 32'd0);
    chk("toreq.busreq_drop", 32'(t_bus_req), 32'd0);
    chk("toreq.stall", 32'(t_stall), 32'd0);
    chk("gntrv.busreq", 32'(bus_req), 32'd1);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; #1;
    chk("gntrv.rspv", 32'(rsp_valid), 32'd1);
    chk("gntrv.rdata", rsp_rdata, 32'h5A5A0001);
    chk("toreq.after_rspv", 32'(t_rsp_valid), 32'd0);
    chk("toreq.after_busreq", 32'(t_bus_req), 32'd0);

    // Timeout in WAIT, then a stray rvalid that u_dut_to must ignore.
    cyc(); issue(1'b0, 32'h500, 32'h0, 2'd2, 1'b0); #1;
    cyc(); req_valid = 1'b0; bus_gnt = 1'b1; #1;
    for (int unsigned c = 2; c <= 4; c++) begin
      cyc(); bus_gnt = 1'b0; #1;
      chk($sformatf("towait.c%0d_rspv", c), 32'(t_rsp_valid), 32'd0);
      chk($sformatf("towait.c%0d_stall", c), 32'(t_stall), 32'd1);
    end
    cyc(); #1;
    chk("towait.rspv", 32'(t_rsp_valid), 32'd1);
    chk("towait.err", 32'(t_rsp_err), 32'd1);
    chk("towait.rdata", t_rsp_rdata, 32'd0);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'h11112222; #1;
    chk("stray.c6_rspv", 32'(t_rsp_valid), 32'd0);
    chk("stray.c6_ready", 32'(t_ready), 32'd1);
    cyc(); bus_rvalid = 1'b0; bus_rdata = '0; #1;
    chk("stray.c7_rspv", 32'(t_rsp_valid), 32'd0);
    chk("stray.c7_busreq", 32'(t_bus_req), 32'd0);
    chk("drain.rspv", 32'(rsp_valid), 32'd1);
    chk("drain.rdata", rsp_rdata, 32'h11112222);

    // Reset asserted while in WAIT.
    cyc(); issue(1'b0, 32'h602, 32'h0, 2'd1, 1'b0); #1;
    cyc(); req_valid = 1'b0; bus_gnt = 1'b1; #1;
    cyc(); bus_gnt = 1'b0; #1;
    chk("rstw.stall_pre", 32'(stall), 32'd1);
    #1 reset_ni = 1'b0; #1;
    chk("rstw.busreq", 32'(bus_req), 32'd0);
    chk("rstw.stall", 32'(stall), 32'd0);
    chk("rstw.ready", 32'(ready), 32'd1);
    chk("rstw.rspv", 32'(rsp_valid), 32'd0);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000; #1;
    chk("rstw.held_rspv", 32'(rsp_valid), 32'd0);
    cyc(); reset_ni = 1'b1; #1;
    chk("rstw.rel_rspv", 32'(rsp_valid), 32'd0);
    cyc(); bus_rvalid = 1'b0; bus_rdata = '0; #1;
    chk("rstw.late_rspv", 32'(rsp_valid), 32'd0);
    chk("rstw.late_busreq", 32'(bus_req), 32'd0);
    run_xfer("post_rst", 1'b0, 32'h602, 32'h0, 2'd1, 1'b0, 32'h80010000, 4'hC, 32'h0, 32'hFFFF8001);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
